// File: rtl/pe_packetizer_pkg.sv
// Shared definitions for the PE packetizer and the mesh router: field widths,
// flit-type codes, packetizer state encodings and the flit layout.
package pe_packetizer_pkg;

  localparam int X                 = 3;
  localparam int Y                 = 3;
  localparam int ID_WIDTH          = 2;
  localparam int DATA_WIDTH        = 24;
  localparam int PKT_NO_FIELD_SIZE = 4;

  localparam int X_SIZE      = $clog2(X);
  localparam int Y_SIZE      = $clog2(Y);
  localparam int TOTAL_WIDTH = X_SIZE + Y_SIZE + PKT_NO_FIELD_SIZE + ID_WIDTH + DATA_WIDTH;

  localparam logic [ID_WIDTH-1:0] FLIT_HEAD = 2'b00;
  localparam logic [ID_WIDTH-1:0] FLIT_BODY = 2'b01;
  localparam logic [ID_WIDTH-1:0] FLIT_TAIL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  // Destination column sits at the MSB end of the flit.
  typedef struct packed {
    logic [X_SIZE-1:0]            x;
    logic [Y_SIZE-1:0]            y;
    logic [PKT_NO_FIELD_SIZE-1:0] pkt_no;
    logic [ID_WIDTH-1:0]          id;
    logic [DATA_WIDTH-1:0]        data;
  } flit_t;

endpackage

// File: rtl/pe_packetizer_if.sv
// Pixel-source and flit-output handshake bundle of the packetizer.
interface pe_packetizer_if;
  import pe_packetizer_pkg::*;

  logic                   pix_valid;
  logic                   pix_ready;
  logic [DATA_WIDTH-1:0]  pix_data;
  logic                   w_valid_pe;
  logic                   w_ready_pe;
  logic [TOTAL_WIDTH-1:0] w_data_pe;

  modport master (
    input  pix_valid, pix_data, w_ready_pe,
    output pix_ready, w_valid_pe, w_data_pe
  );

  modport slave (
    output pix_valid, pix_data, w_ready_pe,
    input  pix_ready, w_valid_pe, w_data_pe
  );

endinterface

// File: rtl/pe_packetizer.sv
// Turns one ROWS x COLS RGB image into a head / body... / tail packet for the
// mesh, with an XOR checksum of all pixels carried in the tail flit.
module pe_packetizer
  import pe_packetizer_pkg::*;
#(
  parameter int ROWS = 273,
  parameter int COLS = 182
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [X_SIZE-1:0]            dest_x,
  input  logic [Y_SIZE-1:0]            dest_y,
  input  logic [PKT_NO_FIELD_SIZE-1:0] pkt_no,
  pe_packetizer_if.master              flit_if,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state_monitor
);

  localparam logic [15:0]           LAST_PIX  = 16'(ROWS * COLS - 1);
  localparam logic [8:0]            LAST_COL  = 9'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] HEAD_DATA = {12'(ROWS), 12'(COLS)};

  logic [1:0]                   state;
  flit_t                        w_flit;
  logic                         w_valid;
  logic [X_SIZE-1:0]            lat_x;
  logic [Y_SIZE-1:0]            lat_y;
  logic [PKT_NO_FIELD_SIZE-1:0] lat_pkt_no;
  logic [15:0]                  pix_count;
  logic [8:0]                   row_cnt;
  logic [8:0]                   col_cnt;
  logic [DATA_WIDTH-1:0]        checksum;
  logic                         all_pix;
  logic                         done_r;

  logic flit_free;
  logic flit_fire;
  logic pix_fire;

  // The output register can take a new flit when empty or emptying this cycle.
  assign flit_free = !w_valid || flit_if.w_ready_pe;
  assign flit_fire = w_valid && flit_if.w_ready_pe;
  // NOTE: pix_ready never looks at pix_valid, so no combinational loop can
  // form with a source that waits for ready before raising valid.
  assign flit_if.pix_ready = (state == ST_BODY) && !all_pix && flit_free;
  assign pix_fire          = flit_if.pix_valid && flit_if.pix_ready;

  assign flit_if.w_valid_pe = w_valid;
  assign flit_if.w_data_pe  = w_flit;
  assign busy               = (state != ST_IDLE);
  assign done               = done_r;
  assign state_monitor      = state;

  // NOTE: all state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      w_flit     <= '0;
      w_valid    <= 1'b0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_pkt_no <= '0;
      pix_count  <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      checksum   <= '0;
      all_pix    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_x      <= dest_x;
            lat_y      <= dest_y;
            lat_pkt_no <= pkt_no;
            pix_count  <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            checksum   <= '0;
            all_pix    <= 1'b0;
            w_valid    <= 1'b1;
            w_flit     <= flit_t'{dest_x, dest_y, pkt_no, FLIT_HEAD, HEAD_DATA};
            state      <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (flit_fire) begin
            w_valid <= 1'b0;
            state   <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (pix_fire) begin
            w_valid  <= 1'b1;
            w_flit   <= flit_t'{lat_x, lat_y, lat_pkt_no, FLIT_BODY, flit_if.pix_data};
            checksum <= checksum ^ flit_if.pix_data;
            if (pix_count == LAST_PIX) begin
              all_pix <= 1'b1;
            end else begin
              pix_count <= pix_count + 16'd1;
            end
            if (col_cnt == LAST_COL) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 9'd1;
            end else begin
              col_cnt <= col_cnt + 9'd1;
            end
          end else if (all_pix && flit_free) begin
            // Tail follows only once the last body flit has been registered.
            w_valid <= 1'b1;
            w_flit  <= flit_t'{lat_x, lat_y, lat_pkt_no, FLIT_TAIL, checksum};
            state   <= ST_TAIL;
          end else if (flit_fire) begin
            w_valid <= 1'b0;
          end
        end
        ST_TAIL: begin
          if (flit_fire) begin
            w_valid <= 1'b0;
            done_r  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_packetizer.md
PE_PACKETIZER -- requirements
Module: pe_packetizer

Interface
REQ-001 Parameters: X=3 mesh columns; Y=3 mesh rows; ID_WIDTH=2 flit-type field; DATA_WIDTH=24 payload (RGB); PKT_NO_FIELD_SIZE=4 packet number; ROWS=273 image rows; COLS=182 image columns.
REQ-002 Derived: X_SIZE=$clog2(X); Y_SIZE=$clog2(Y); TOTAL_WIDTH=X_SIZE+Y_SIZE+PKT_NO_FIELD_SIZE+ID_WIDTH+DATA_WIDTH (34 with defaults).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to send one image packet.
REQ-006 dest_x  in  X_SIZE  destination column, sampled on accepted start.
REQ-007 dest_y  in  Y_SIZE  destination row, sampled on accepted start.
REQ-008 pkt_no  in  PKT_NO_FIELD_SIZE  packet number, sampled on accepted start.
REQ-009 pix_valid  in  1  pixel source valid.
REQ-010 pix_ready  out  1  pixel accepted when pix_valid && pix_ready.
REQ-011 pix_data  in  DATA_WIDTH  pixel {R,G,B}, row-major.
REQ-012 w_valid_pe  out  1  flit valid toward PE/router.
REQ-013 w_ready_pe  in  1  downstream ready.
REQ-014 w_data_pe  out  TOTAL_WIDTH  flit {x, y, pkt_no, id, data}, x at MSB.
REQ-015 busy  out  1  high from accepted start until tail handshake.
REQ-016 done  out  1  one-cycle pulse the cycle after tail handshake.
REQ-017 state_monitor  out  2  current FSM state encoding.

Function
REQ-018 FSM states: IDLE=0, HEAD=1, BODY=2, TAIL=3; state_monitor = state.
REQ-019 IDLE->HEAD on start; start ignored in any other state.
REQ-020 HEAD: present head flit id=2'b00, data={ROWS[11:0],COLS[11:0]}; ->BODY on handshake.
REQ-021 BODY: one body flit id=2'b01 per accepted pixel, data=pix_data unchanged; ->TAIL after ROWS*COLS pixels accepted.
REQ-022 TAIL: tail flit id=2'b11, data=XOR of all ROWS*COLS pixels; ->IDLE on handshake.
REQ-023 Every flit carries latched dest_x, dest_y, pkt_no in its header fields.
REQ-024 Flit is a single output register: w_valid_pe/w_data_pe held stable until w_valid_pe && w_ready_pe; no drop, no duplicate.
REQ-025 pix_ready = (state==BODY) && (pixels_remaining>0) && (!w_valid_pe || w_ready_pe); combinational, no dependence on pix_valid.
REQ-026 Latency: accepted pixel appears as w_data_pe on the next rising edge; full throughput of one flit/cycle with w_ready_pe held high.
REQ-027 Pixel counter 16 bits, counts 0..ROWS*COLS-1; row/col counters 9 bits wrap col at COLS-1 and increment row; counters cleared on start.
REQ-028 Checksum register cleared on start, XOR-accumulated on each pixel handshake.
REQ-029 Simultaneous last-body handshake and last-pixel accept impossible by REQ-025; tail is issued only after last body flit is registered.
REQ-030 pix_valid while not in BODY: ignored, pix_ready=0.
REQ-031 w_ready_pe low indefinitely: all state frozen, no pixel accepted.

Reset
REQ-032 rstn low: state=IDLE, w_valid_pe=0, w_data_pe=0, pix_ready=0, busy=0, done=0, counters/checksum/latched fields=0.
REQ-033 Reset mid-packet abandons it; no tail emitted; next start begins a fresh packet.

Structure
REQ-034 Shared package holds flit-type constants FLIT_HEAD/BODY/TAIL, state encodings, and the field-width parameters used by the PE and router.
REQ-035 Single module; no sub-module required.

Verification
REQ-036 ROWS=2,COLS=3, start with dest (1,2), pkt_no=5, pixels 0x000001..0x000006, w_ready_pe=1 -> head data 0x002003, six body flits in order, tail data 0x000007, done one cycle after tail.
REQ-037 Same, w_ready_pe toggled every other cycle -> identical flit sequence, no gaps in data, w_data_pe stable while stalled.
REQ-038 start pulsed again during BODY -> ignored; dest/pkt_no fields unchanged through tail.
REQ-039 rstn low after third body flit -> outputs zero immediately, state_monitor=0; new start yields complete packet.
REQ-040 Defaults 273x182 random image -> 49686 body flits, tail equals reference XOR, header fields constant.
